// File: rtl/alu_regfile_pipe_if.sv
// Request/result bundle for alu_regfile_pipe.
// The master presents operations and observes results; the slave is the pipeline.
interface alu_regfile_pipe_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     ALUsrc;
  logic [2:0]               ALUctrl;
  logic                     RegWrite;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    ALUout;
  logic                     EQ;
  logic                     LT;
  logic [DATA_WIDTH-1:0]    a0;

  modport master (
    output in_valid, rs1, rs2, rd, ImmOp, ALUsrc, ALUctrl, RegWrite,
    input  in_ready, out_valid, ALUout, EQ, LT, a0
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, ImmOp, ALUsrc, ALUctrl, RegWrite,
    output in_ready, out_valid, ALUout, EQ, LT, a0
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU + register file: EX computes from live operands into the result register; WB commits it to rd one edge later.
// No downstream backpressure; a RAW hit on the pending write stalls one cycle unless ALU_REGFILE_FORWARD_EN is defined.
module alu_regfile_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int A0_INDEX      = 10
) (
  input logic               clk,
  input logic               rst_n,
  alu_regfile_pipe_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;
  localparam int SHAMT_W  = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  eq;
    logic                  lt;
  } ex_res_t;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  ex_res_t                             res_q, res_d;
  logic                                out_valid_q, out_valid_d;
  logic                                wb_we_q, wb_we_d;
  logic [ADDRESS_WIDTH-1:0]            wb_rd_q, wb_rd_d;

  logic [DATA_WIDTH-1:0] rf_rs1, rf_rs2;
  logic [DATA_WIDTH-1:0] op1, op2, ex_result;
  logic                  rs1_hit, rs2_hit;
  logic                  ex_eq, ex_lt;
  logic                  fire;
  logic [SHAMT_W-1:0]    shamt;

  // Register 0 is hardwired to zero on the read side as well.
  always_comb begin
    rf_rs1 = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
    rf_rs2 = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
  end

  // wb_we_q is only ever set for rd != 0, so x0 can never be matched here.
  always_comb begin
    rs1_hit = wb_we_q && (bus.rs1 == wb_rd_q);
    rs2_hit = wb_we_q && !bus.ALUsrc && (bus.rs2 == wb_rd_q);
  end

`ifdef ALU_REGFILE_FORWARD_EN
  always_comb begin
    bus.in_ready = rst_n;
    op1          = rs1_hit ? res_q.result : rf_rs1;
    op2          = bus.ALUsrc ? bus.ImmOp : (rs2_hit ? res_q.result : rf_rs2);
  end
`else
  logic stall;

  always_comb begin
    stall        = bus.in_valid && (rs1_hit || rs2_hit);
    bus.in_ready = rst_n && !stall;
    op1          = rf_rs1;
    op2          = bus.ALUsrc ? bus.ImmOp : rf_rs2;
  end
`endif

  assign fire = bus.in_valid && bus.in_ready;

  always_comb begin
    shamt     = op2[SHAMT_W-1:0];
    ex_eq     = (op1 == op2);
    ex_lt     = ($signed(op1) < $signed(op2));
    ex_result = '0;
    case (alu_op_e'(bus.ALUctrl))
      ALU_ADD: ex_result = op1 + op2;
      ALU_SUB: ex_result = op1 - op2;
      ALU_AND: ex_result = op1 & op2;
      ALU_OR:  ex_result = op1 | op2;
      ALU_XOR: ex_result = op1 ^ op2;
      ALU_SLL: ex_result = op1 << shamt;
      ALU_SRL: ex_result = op1 >> shamt;
      ALU_SLT: ex_result = {{(DATA_WIDTH-1){1'b0}}, ex_lt};
      default: ex_result = '0;
    endcase
  end

  // The result register doubles as the WB data; it commits on the edge after capture.
  always_comb begin
    res_d       = res_q;
    out_valid_d = fire;
    wb_we_d     = fire && bus.RegWrite && (bus.rd != '0);
    wb_rd_d     = wb_rd_q;
    regs_d      = regs_q;
    if (fire) begin
      res_d.result = ex_result;
      res_d.eq     = ex_eq;
      res_d.lt     = ex_lt;
      wb_rd_d      = bus.rd;
    end
    if (wb_we_q) begin
      regs_d[wb_rd_q] = res_q.result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q      <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
    end else begin
      regs_q      <= regs_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  always_comb begin
    bus.out_valid = out_valid_q;
    bus.ALUout    = res_q.result;
    bus.EQ        = res_q.eq;
    bus.LT        = res_q.lt;
    bus.a0        = regs_q[A0_INDEX];
  end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe: vector table, corner-case sequences, random ops vs. a program-order model.
module tb_alu_regfile_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int A0 = 10;

`ifdef ALU_REGFILE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_regfile_pipe_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  alu_regfile_pipe #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .A0_INDEX(A0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // arch_regs: values in program order; comm_regs: values already visible on a0.
  logic [DW-1:0] arch_regs [NR];
  logic [DW-1:0] comm_regs [NR];
  logic          pend_we;
  logic [AW-1:0] pend_rd;
  logic [DW-1:0] pend_val;
  logic          e_valid, e_eq, e_lt;
  logic [DW-1:0] e_alu;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] x1;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_alu;
    logic          exp_eq;
    logic          exp_lt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int unsigned   sh;
    logic [DW-1:0] r;
    sh = b % DW;
    r  = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: r[0] = ($signed(a) < $signed(b));
    endcase
    return r;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2, input logic [AW-1:0] d, input logic [DW-1:0] imm,
                      input logic src, input logic [2:0] op, input logic we, output logic fired);
    logic          hz, exp_rdy;
    logic [DW-1:0] a, b;
    @(negedge clk);
    rst_n        = rst;
    bus.in_valid = v;
    bus.rs1      = r1;
    bus.rs2      = r2;
    bus.rd       = d;
    bus.ImmOp    = imm;
    bus.ALUsrc   = src;
    bus.ALUctrl  = op;
    bus.RegWrite = we;
    #1;
    hz      = pend_we && ((r1 == pend_rd) || (!src && (r2 == pend_rd)));
    exp_rdy = rst && (FWD || !(v && hz));
    check("in_ready", bus.in_ready, exp_rdy);
    fired = v && exp_rdy;
    a = arch_regs[r1];
    b = src ? imm : arch_regs[r2];
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        arch_regs[i] = '0;
        comm_regs[i] = '0;
      end
      pend_we = 1'b0;
      e_valid = 1'b0;
      e_alu   = '0;
      e_eq    = 1'b0;
      e_lt    = 1'b0;
    end else begin
      if (pend_we) comm_regs[pend_rd] = pend_val;
      pend_we = 1'b0;
      e_valid = fired;
      if (fired) begin
        e_alu = alu_ref(op, a, b);
        e_eq  = (a == b);
        e_lt  = ($signed(a) < $signed(b));
        if (we && d != 0) begin
          arch_regs[d] = e_alu;
          pend_we      = 1'b1;
          pend_rd      = d;
          pend_val     = e_alu;
        end
      end
    end
    #1;
    check("out_valid", bus.out_valid, e_valid);
    check("ALUout", bus.ALUout, e_alu);
    check("EQ", bus.EQ, e_eq);
    check("LT", bus.LT, e_lt);
    check("a0", bus.a0, comm_regs[A0]);
  endtask

  task automatic idle();
    logic f;
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 1'b0, f);
  endtask

  task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] d,
                       input logic [DW-1:0] imm, input logic src, input logic [2:0] op,
                       input logic we, output int cycles);
    logic f;
    f      = 1'b0;
    cycles = 0;
    while (!f && cycles < 4) begin
      step(1'b1, 1'b1, r1, r2, d, imm, src, op, we, f);
      cycles++;
    end
    if (!f) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got no fire after %0d cycles, required fire", cycles);
    end
  endtask

  initial begin : main
    int            c;
    logic          f;
    logic [AW-1:0] pool [5];
    for (int i = 0; i < NR; i++) begin
      arch_regs[i] = '0;
      comm_regs[i] = '0;
    end
    pend_we = 1'b0; pend_rd = '0; pend_val = '0;
    e_valid = 1'b0; e_alu = '0; e_eq = 1'b0; e_lt = 1'b0;
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd10};

    vecs[0]  = '{3'd0, 32'h0000_0000, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    vecs[2]  = '{3'd7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{3'd5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b1};
    vecs[4]  = '{3'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b1};
    vecs[5]  = '{3'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b1};
    vecs[6]  = '{3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b1};
    vecs[7]  = '{3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b1};
    vecs[8]  = '{3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b1};
    vecs[9]  = '{3'd7, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0001, 1'b0, 1'b1};
    vecs[10] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    vecs[11] = '{3'd1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};

    // Reset with an operation presented: it must not be accepted.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 3'd0, 1'b1, f);
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 3'd0, 1'b1, f);
    idle();

    foreach (vecs[i]) begin
      issue(5'd0, 5'd0, 5'd1, vecs[i].x1, 1'b1, 3'd0, 1'b1, c);
      issue(5'd1, 5'd0, 5'd2, vecs[i].imm, 1'b1, vecs[i].op, 1'b1, c);
      check($sformatf("vec%0d_alu", i), bus.ALUout, vecs[i].exp_alu);
      check($sformatf("vec%0d_eq", i), bus.EQ, vecs[i].exp_eq);
      check($sformatf("vec%0d_lt", i), bus.LT, vecs[i].exp_lt);
    end

    // Back-to-back RAW on both sources.
    issue(5'd0, 5'd0, 5'd1, 32'd7, 1'b1, 3'd0, 1'b1, c);
    issue(5'd1, 5'd1, 5'd10, 32'd0, 1'b0, 3'd1, 1'b1, c);
    check("raw_cycles", c, FWD ? 1 : 2);
    check("raw_alu", bus.ALUout, 32'd0);
    check("raw_eq", bus.EQ, 32'd1);
    check("raw_a0", bus.a0, 32'd0);
    idle();

    // Writes to x0 are dropped and never forwarded.
    issue(5'd0, 5'd0, 5'd0, 32'd9, 1'b1, 3'd0, 1'b1, c);
    issue(5'd0, 5'd0, 5'd3, 32'd0, 1'b1, 3'd0, 1'b1, c);
    check("x0_cycles", c, 1);
    check("x0_alu", bus.ALUout, 32'd0);

    // a0 lags the write by one edge.
    issue(5'd0, 5'd0, 5'd10, 32'h55, 1'b1, 3'd0, 1'b1, c);
    check("a0_lag", bus.a0, 32'd0);
    idle();
    check("a0_commit", bus.a0, 32'h55);

    // Reset while a write sits in WB.
    issue(5'd0, 5'd0, 5'd10, 32'd3, 1'b1, 3'd0, 1'b1, c);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 3'd0, 1'b0, f);
    check("rst_out_valid", bus.out_valid, 32'd0);
    idle();
    check("rst_a0", bus.a0, 32'd0);
    issue(5'd10, 5'd0, 5'd4, 32'd0, 1'b1, 3'd0, 1'b1, c);
    check("rst_x10", bus.ALUout, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] imm;
      imm = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8),
           pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
           imm, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
